// File: rtl/imm_encoder.sv
// RISC-V immediate encoder: packs a signed immediate into the fields of an
// instruction word, flags range/alignment errors, and buffers results in a 2-deep FIFO.
module imm_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_imm,
  input  logic [2:0]  in_src,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [1:0]  out_err,
  output logic [15:0] err_count
);

  typedef enum logic [2:0] {
    SRC_I     = 3'b000,
    SRC_S     = 3'b001,
    SRC_B     = 3'b010,
    SRC_U     = 3'b011,
    SRC_J     = 3'b100,
    SRC_SHAMT = 3'b101
  } src_e;

  function automatic logic out_of_range(input logic signed [31:0] v,
                                        input logic signed [31:0] lo,
                                        input logic signed [31:0] hi);
    return (v < lo) || (v > hi);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic signed [31:0] imm_s;
  logic        [31:0] enc_instr_p0;
  logic        [1:0]  enc_err_p0;

  // Stage p0: combinational field packing and error detection
  always_comb begin
    imm_s        = $signed(in_imm);
    enc_instr_p0 = in_instr;
    enc_err_p0   = 2'b00;
    case (in_src)
      SRC_I: begin
        enc_instr_p0[31:20] = in_imm[11:0];
        enc_err_p0[0]       = out_of_range(imm_s, -32'sd2048, 32'sd2047);
      end
      SRC_S: begin
        enc_instr_p0[31:25] = in_imm[11:5];
        enc_instr_p0[11:7]  = in_imm[4:0];
        enc_err_p0[0]       = out_of_range(imm_s, -32'sd2048, 32'sd2047);
      end
      SRC_B: begin
        enc_instr_p0[31]    = in_imm[12];
        enc_instr_p0[7]     = in_imm[11];
        enc_instr_p0[30:25] = in_imm[10:5];
        enc_instr_p0[11:8]  = in_imm[4:1];
        enc_err_p0[0]       = out_of_range(imm_s, -32'sd4096, 32'sd4094);
        enc_err_p0[1]       = in_imm[0];
      end
      SRC_U: begin
        enc_instr_p0[31:12] = in_imm[31:12];
        enc_err_p0[0]       = (in_imm[11:0] != 12'd0);
      end
      SRC_J: begin
        enc_instr_p0[31]    = in_imm[20];
        enc_instr_p0[19:12] = in_imm[19:12];
        enc_instr_p0[20]    = in_imm[11];
        enc_instr_p0[30:21] = in_imm[10:1];
        enc_err_p0[0]       = out_of_range(imm_s, -32'sd1048576, 32'sd1048574);
        enc_err_p0[1]       = in_imm[0];
      end
      SRC_SHAMT: begin
        enc_instr_p0[24:20] = in_imm[4:0];
        enc_err_p0[0]       = (in_imm > 32'd31);
      end
      default: enc_err_p0 = 2'b11;
    endcase
  end

  // Stage p1: two-entry result FIFO; storage itself is not reset
  logic [31:0] fifo_instr_p1 [2];
  logic [1:0]  fifo_err_p1   [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  occ;
  logic        push;
  logic        pop;

  // A full buffer still accepts when the head leaves in the same cycle
  assign in_ready  = rst_n & ((occ != 2'd2) | out_ready);
  assign push      = in_valid & in_ready;
  assign out_valid = (occ != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_instr = out_valid ? fifo_instr_p1[rd_ptr] : 32'd0;
  assign out_err   = out_valid ? fifo_err_p1[rd_ptr] : 2'b00;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_p1[wr_ptr] <= enc_instr_p0;
      fifo_err_p1[wr_ptr]   <= enc_err_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occ       <= 2'd0;
      err_count <= 16'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push && !pop)      occ <= occ + 2'd1;
      else if (!push && pop) occ <= occ - 2'd1;
      if (pop && (out_err != 2'b00)) err_count <= sat_inc(err_count);
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed vectors plus a scoreboard fed
// from an independent field-packing model.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_imm;
  logic [2:0]  in_src;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [1:0]  out_err;
  logic [15:0] err_count;

  imm_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_imm    (in_imm),
    .in_src    (in_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  err;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_errcnt = 16'd0;

  function automatic exp_t model(input logic [31:0] w, input logic [31:0] imm,
                                 input logic [2:0] src);
    exp_t e;
    int   v;
    v     = imm;
    e.err = 2'b00;
    case (src)
      3'd0: begin
        e.instr  = {imm[11:0], w[19:0]};
        e.err[0] = (v < -2048) || (v > 2047);
      end
      3'd1: begin
        e.instr  = {imm[11:5], w[24:12], imm[4:0], w[6:0]};
        e.err[0] = (v < -2048) || (v > 2047);
      end
      3'd2: begin
        e.instr  = {imm[12], imm[10:5], w[24:12], imm[4:1], imm[11], w[6:0]};
        e.err[0] = (v < -4096) || (v > 4094);
        e.err[1] = imm[0];
      end
      3'd3: begin
        e.instr  = {imm[31:12], w[11:0]};
        e.err[0] = (imm[11:0] != 12'd0);
      end
      3'd4: begin
        e.instr  = {imm[20], imm[10:1], imm[11], imm[19:12], w[11:0]};
        e.err[0] = (v < -1048576) || (v > 1048574);
        e.err[1] = imm[0];
      end
      3'd5: begin
        e.instr  = {w[31:25], imm[4:0], w[19:0]};
        e.err[0] = (imm > 32'd31);
      end
      default: begin
        e.instr = w;
        e.err   = 2'b11;
      end
    endcase
    return e;
  endfunction

  // Runs forever alongside the tests: records accepted requests, checks delivered results
  task automatic scoreboard_monitor();
    exp_t        e;
    logic        hold_chk = 1'b0;
    logic [31:0] hold_instr = 32'd0;
    logic [1:0]  hold_err = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        exp_errcnt = 16'd0;
        hold_chk   = 1'b0;
      end else begin
        if (hold_chk) begin
          total++;
          if (out_valid !== 1'b1 || out_instr !== hold_instr || out_err !== hold_err) begin
            bad++;
            $display("FAIL hold_stable: got v=%b %h/%b required v=1 %h/%b",
                     out_valid, out_instr, out_err, hold_instr, hold_err);
          end
        end
        hold_chk   = out_valid && !out_ready;
        hold_instr = out_instr;
        hold_err   = out_err;
        if (out_valid && out_ready) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got %h/%b required no output", out_instr, out_err);
          end else begin
            e = sb.pop_front();
            if (out_instr !== e.instr || out_err !== e.err) begin
              bad++;
              $display("FAIL sb_result: got %h/%b required %h/%b",
                       out_instr, out_err, e.instr, e.err);
            end
            if (e.err != 2'b00 && exp_errcnt != 16'hFFFF) exp_errcnt++;
          end
        end
        if (in_valid && in_ready) sb.push_back(model(in_instr, in_imm, in_src));
      end
    end
  endtask

  task automatic send(input logic [31:0] w, input logic [31:0] imm, input logic [2:0] src);
    int n = 0;
    in_valid = 1'b1;
    in_instr = w;
    in_imm   = imm;
    in_src   = src;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles required 1", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending required 0", sb.size());
    end
    total++;
    if (err_count !== exp_errcnt) begin
      bad++;
      $display("FAIL err_count: got %0d required %0d", err_count, exp_errcnt);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_instr  = 32'h00000013;
    in_imm    = 32'd0;
    in_src    = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || out_instr !== 32'd0 || out_err !== 2'b00 ||
        err_count !== 16'd0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got v=%b i=%h e=%b c=%0d r=%b required 0 0 0 0 0",
               out_valid, out_instr, out_err, err_count, in_ready);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset: got %b required 1", in_ready);
    end
  endtask

  task automatic test_i_type();
    out_ready = 1'b1;
    send(32'h00000013, 32'hFFFFFFFF, 3'd0);
    total++;
    if (out_valid !== 1'b1 || out_instr !== 32'hFFF00013 || out_err !== 2'b00) begin
      bad++;
      $display("FAIL i_type: got v=%b %h/%b required v=1 fff00013/00",
               out_valid, out_instr, out_err);
    end
    drain();
  endtask

  task automatic test_b_type();
    logic [15:0] c0;
    send(32'h00000063, 32'hFFFFFFFC, 3'd2);
    total++;
    if (out_instr !== 32'hFE000EE3 || out_err !== 2'b00) begin
      bad++;
      $display("FAIL b_type: got %h/%b required fe000ee3/00", out_instr, out_err);
    end
    drain();
    c0 = err_count;
    send(32'h00000063, 32'd3, 3'd2);
    total++;
    if (out_err[1] !== 1'b1) begin
      bad++;
      $display("FAIL b_align: got err=%b required bit1=1", out_err);
    end
    drain();
    total++;
    if (err_count !== c0 + 16'd1) begin
      bad++;
      $display("FAIL b_errcnt: got %0d required %0d", err_count, c0 + 16'd1);
    end
  endtask

  task automatic test_range();
    send(32'h00000013, 32'd2048, 3'd0);
    total++;
    if (out_err !== 2'b01) begin
      bad++;
      $display("FAIL i_range: got %b required 01", out_err);
    end
    send(32'h00000013, 32'd32, 3'd5);
    total++;
    if (out_err !== 2'b01 || out_instr[24:20] !== 5'd0) begin
      bad++;
      $display("FAIL shamt_range: got %b/%h required 01/00", out_err, out_instr[24:20]);
    end
    send(32'h00000037, 32'h12345000, 3'd3);
    total++;
    if (out_instr[31:12] !== 20'h12345 || out_err !== 2'b00) begin
      bad++;
      $display("FAIL u_type: got %h/%b required 12345/00", out_instr[31:12], out_err);
    end
    send(32'hABCD1234, 32'd5, 3'd6);
    total++;
    if (out_instr !== 32'hABCD1234 || out_err !== 2'b11) begin
      bad++;
      $display("FAIL bad_src: got %h/%b required abcd1234/11", out_instr, out_err);
    end
    // Boundary values, checked through the scoreboard
    send(32'h00000063, 32'd4094, 3'd2);
    send(32'h00000063, 32'd4096, 3'd2);
    send(32'h00000063, -32'sd4096, 3'd2);
    send(32'h00000063, -32'sd4098, 3'd2);
    send(32'h0000006F, 32'd1048574, 3'd4);
    send(32'h0000006F, 32'd1048576, 3'd4);
    send(32'h0000006F, -32'sd1048576, 3'd4);
    send(32'h0000006F, 32'd1235, 3'd4);
    send(32'h00000023, 32'd2047, 3'd1);
    send(32'h00000023, -32'sd2049, 3'd1);
    send(32'h00000013, -32'sd2048, 3'd0);
    send(32'h00001013, 32'd31, 3'd5);
    send(32'h00000037, 32'h00000800, 3'd3);
    send(32'h00000000, 32'd0, 3'd7);
    drain();
  endtask

  task automatic test_back_to_back();
    time t0;
    out_ready = 1'b1;
    t0 = $time;
    for (int i = 0; i < 16; i++)
      send($urandom, ($urandom_range(0, 1) == 0) ? $urandom_range(0, 4200) : $urandom,
           3'($urandom_range(0, 7)));
    total++;
    if ($time - t0 !== 160) begin
      bad++;
      $display("FAIL throughput: got %0t required 160", $time - t0);
    end
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(32'h00000013, 32'd1, 3'd0);
    send(32'h00000013, 32'd2, 3'd0);
    in_valid = 1'b1;
    in_instr = 32'h00000013;
    in_imm   = 32'd3;
    in_src   = 3'd0;
    repeat (2) @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL full_ready: got r=%b v=%b required r=0 v=1", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h00000013, 32'd3, 3'd0);
    drain();
    fork
      begin
        for (int i = 0; i < 24; i++)
          send($urandom, $urandom_range(0, 5000), 3'($urandom_range(0, 5)));
      end
      begin
        for (int k = 0; k < 70; k++) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(32'h00000063, 32'd3, 3'd2);
    send(32'h00000013, 32'd7, 3'd0);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || err_count !== 16'd0 || in_ready !== 1'b0 ||
        out_instr !== 32'd0) begin
      bad++;
      $display("FAIL async_reset: got v=%b c=%0d r=%b i=%h required 0 0 0 0",
               out_valid, err_count, in_ready, out_instr);
    end
    repeat (2) @(posedge clk);
    #3;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(32'h00000013, 32'hFFFFFFFF, 3'd0);
    total++;
    if (out_valid !== 1'b1 || out_instr !== 32'hFFF00013 || out_err !== 2'b00) begin
      bad++;
      $display("FAIL post_reset_flow: got v=%b %h/%b required v=1 fff00013/00",
               out_valid, out_instr, out_err);
    end
    drain();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_instr  = 32'd0;
    in_imm    = 32'd0;
    in_src    = 3'd0;
    fork
      scoreboard_monitor();
    join_none
    test_reset();
    test_i_type();
    test_b_type();
    test_range();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 The block SHALL expose these ports: clk  in  1  sole clock, rising edge.
REQ-002 The block SHALL expose: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 The block SHALL expose: in_valid  in  1  request valid.
REQ-004 The block SHALL expose: in_ready  out  1  block can accept a request.
REQ-005 The block SHALL expose: in_instr  in  32  base instruction word; its immediate fields are overwritten.
REQ-006 The block SHALL expose: in_imm  in  32  signed immediate, or unsigned for type 101.
REQ-007 The block SHALL expose: in_src  in  3  immediate type: 000 I, 001 S, 010 B, 011 U, 100 J, 101 SHAMT.
REQ-008 The block SHALL expose: out_valid  out  1  result valid.
REQ-009 The block SHALL expose: out_ready  in  1  consumer accepts the result.
REQ-010 The block SHALL expose: out_instr  out  32  encoded instruction.
REQ-011 The block SHALL expose: out_err  out  2  bit0 range error, bit1 alignment error.
REQ-012 The block SHALL expose: err_count  out  16  saturating count of errored results delivered.

Function
REQ-013 A transfer SHALL occur on a clk edge where valid and ready are both 1, on either side.
REQ-014 Field packing SHALL be as follows. I: [31:20]=imm[11:0]. S: [31:25]=imm[11:5], [11:7]=imm[4:0]. B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]. U: [31:12]=imm[31:12]. J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1]. SHAMT: [24:20]=imm[4:0].
REQ-015 Bits of the word not named for the selected type SHALL pass through from in_instr unchanged.
REQ-016 Range error conditions SHALL be: I/S imm outside [-2048, 2047]; B outside [-4096, 4094]; J outside [-1048576, 1048574]; U imm[11:0] != 0; SHAMT imm outside [0, 31].
REQ-017 An alignment error SHALL be flagged for B or J when imm[0] = 1.
REQ-018 in_src values 110 or 111 SHALL set out_err = 11 and pass out_instr = in_instr unchanged.
REQ-019 On any error the encoded word SHALL still be produced from the truncated fields.
REQ-020 Results SHALL be held in a 2-entry FIFO output buffer, with occupancy 0, 1 or 2.
REQ-021 Latency SHALL be 1 cycle: a request accepted at edge N with an empty buffer appears on out_* after edge N, valid in cycle N+1.
REQ-022 in_ready SHALL be 1 when occupancy < 2, or when occupancy = 2 and out_ready = 1 (same-cycle pop frees a slot).
REQ-023 A simultaneous push and pop SHALL leave occupancy unchanged and preserve FIFO order.
REQ-024 out_valid SHALL be 1 exactly when occupancy > 0; out_* SHALL be held stable while out_valid = 1 and out_ready = 0.
REQ-025 err_count SHALL increment by 1 on each output transfer with out_err != 00, and saturate at 16'hFFFF.
REQ-026 The block SHALL sustain 1 request per cycle when out_ready is held at 1.

Reset
REQ-027 While rst_n = 0, occupancy SHALL be 0, out_valid 0, out_instr 0, out_err 00, err_count 0, and in_ready 0.
REQ-028 in_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-029 Assertion of rst_n mid-operation SHALL discard all buffered results immediately, without waiting for a clk edge.

Verification
REQ-030 I-type test: in_instr=32'h00000013, imm=-1, src=000 -> out_instr=32'hFFF00013, out_err=00, one cycle after acceptance.
REQ-031 B-type tests: in_instr=32'h00000063, imm=-4, src=010 -> out_instr=32'hFE000EE3, err 00. imm=3 -> out_err bit1=1, err_count increments on delivery.
REQ-032 Range tests: src=000, imm=2048 -> out_err=01. src=101, imm=32 -> out_err=01, field [24:20]=0. src=011, imm=32'h12345000 -> [31:12]=12345, err 00.
REQ-033 Backpressure test: hold out_ready=0 and push 3 requests -> in_ready falls after 2 are accepted; release out_ready -> results emerge in order with no loss or duplication.
REQ-034 Reset test: assert rst_n low with 2 entries buffered -> out_valid drops without a clk edge, err_count=0; after release, one new request flows with latency 1.
